// File: rtl/axi_ad7124_frame_reader.sv
// AD7124 frame reader: pulls 124-word frames out of the shared BRAM and streams them as AXI4-Stream.
// Optional feature macro: AXI_AD7124_SEQ_CHECK_EN (sequence-continuity check on word 1).
module axi_ad7124_frame_reader #(
  parameter int          FRAME_LENGTH  = 124,
  parameter int          PAYLOAD_START = 16,
  parameter logic [31:0] FRAME_TYPE    = 32'h1234abcd,
  parameter int          FIFO_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_irq,
  output logic        bram_clk,
  output logic        bram_rst,
  output logic        bram_en,
  output logic [12:0] bram_addr,
  input  logic [31:0] bram_dout,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  output logic        busy,
  output logic [31:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] bad_type_cnt,
  output logic [15:0] seq_err_cnt
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int FLT_W = CNT_W + 2;
  localparam logic [10:0] LAST_IDX = 11'(FRAME_LENGTH - 1);
  localparam logic [10:0] PAY_IDX  = 11'(PAYLOAD_START);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_CMP, S_STREAM, S_DRAIN} state_t;

  state_t             state;
  logic               irq_prev;
  logic               trigger;
  logic [10:0]        rd_idx;
  logic               stream_rd;
  logic               pend_valid;
  logic               pend_user;
  logic               pend_last;
  logic [33:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               push;
  logic               pop;
  logic               accept;
  logic [FLT_W-1:0]   in_flight;
  logic               credit;

  assign bram_clk  = clk;
  assign bram_rst  = ~resetn;
  assign trigger   = frame_irq & ~irq_prev;
  assign stream_rd = (state == S_STREAM) || (state == S_DRAIN);
  assign push      = pend_valid;
  assign pop       = (fifo_count != '0) && (!m_axis_tvalid || m_axis_tready);
  assign accept    = m_axis_tvalid && m_axis_tready;

  // Credit counts every word that may still land in the FIFO, ignoring a concurrent pop,
  // so the FIFO cannot overflow whatever tready does.
  assign in_flight = {2'b00, fifo_count} + {{(FLT_W-1){1'b0}}, bram_en}
                   + {{(FLT_W-1){1'b0}}, pend_valid};
  assign credit    = in_flight < FLT_W'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      irq_prev     <= 1'b0;
      bram_en      <= 1'b0;
      bram_addr    <= '0;
      rd_idx       <= '0;
      frame_cnt    <= '0;
      drop_cnt     <= '0;
      bad_type_cnt <= '0;
    end else begin
      irq_prev <= frame_irq;
      bram_en  <= 1'b0;
      if (trigger && state != S_IDLE && drop_cnt != '1)
        drop_cnt <= drop_cnt + 16'd1;
      case (state)
        S_IDLE: begin
          if (trigger) begin
            state     <= S_CHECK;
            busy      <= 1'b1;
            bram_en   <= 1'b1;
            bram_addr <= '0;
          end
        end
        S_CHECK: state <= S_CMP;
        S_CMP: begin
          if (bram_dout == FRAME_TYPE) begin
            // First stream read goes out on the same edge as the compare.
            state     <= S_STREAM;
            bram_en   <= 1'b1;
            bram_addr <= '0;
            rd_idx    <= 11'd1;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            if (bad_type_cnt != '1)
              bad_type_cnt <= bad_type_cnt + 16'd1;
          end
        end
        S_STREAM: begin
          if (credit) begin
            bram_en   <= 1'b1;
            bram_addr <= {rd_idx, 2'b00};
            rd_idx    <= (rd_idx == 11'd3) ? PAY_IDX : rd_idx + 11'd1;
            if (rd_idx == LAST_IDX)
              state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (accept && m_axis_tlast && fifo_count == '0 && !pend_valid) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            frame_cnt <= frame_cnt + 32'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Return stage tags, FIFO pointers and the registered AXIS output slot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_valid    <= 1'b0;
      pend_user     <= 1'b0;
      pend_last     <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
    end else begin
      pend_valid <= bram_en && stream_rd;
      pend_user  <= (bram_addr[12:2] == 11'd0);
      pend_last  <= (bram_addr[12:2] == LAST_IDX);
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        m_axis_tvalid <= 1'b1;
        {m_axis_tlast, m_axis_tuser, m_axis_tdata} <= fifo_mem[rd_ptr];
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {pend_last, pend_user, bram_dout};
  end

`ifdef AXI_AD7124_SEQ_CHECK_EN
  logic        pend_word1;
  logic        last_seq_valid;
  logic [31:0] last_seq;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_word1     <= 1'b0;
      last_seq_valid <= 1'b0;
      last_seq       <= '0;
      seq_err_cnt    <= '0;
    end else begin
      pend_word1 <= bram_en && stream_rd && (bram_addr[12:2] == 11'd1);
      if (push && pend_word1) begin
        last_seq       <= bram_dout;
        last_seq_valid <= 1'b1;
        if (last_seq_valid && bram_dout != last_seq + 32'd1 && seq_err_cnt != '1)
          seq_err_cnt <= seq_err_cnt + 16'd1;
      end
    end
  end
`else
  assign seq_err_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_ad7124_frame_reader.sv
// Scoreboard bench for axi_ad7124_frame_reader: BRAM model, expected-beat queue, separate monitor.
module tb_axi_ad7124_frame_reader;
  localparam logic [31:0] FRAME_TYPE = 32'h1234abcd;
  localparam int          FIFO_DEPTH = 4;
`ifdef AXI_AD7124_SEQ_CHECK_EN
  localparam logic [15:0] SEQ_ERR_EXP = 16'd1;
`else
  localparam logic [15:0] SEQ_ERR_EXP = 16'd0;
`endif

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_irq = 1'b0;
  logic        bram_clk, bram_rst, bram_en;
  logic [12:0] bram_addr;
  logic [31:0] bram_dout = '0;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast, m_axis_tuser, busy;
  logic [31:0] frame_cnt;
  logic [15:0] drop_cnt, bad_type_cnt, seq_err_cnt;

  logic [31:0] frame_mem [0:127];
  logic [63:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int en_count = 0;
  int en_base = 0;
  int acc_base = 0;
  int max_inflight = 0;
  bit track_on = 1'b0;
  bit bp_on = 1'b0;

  axi_ad7124_frame_reader dut (
    .clk(clk), .resetn(resetn), .frame_irq(frame_irq),
    .bram_clk(bram_clk), .bram_rst(bram_rst), .bram_en(bram_en),
    .bram_addr(bram_addr), .bram_dout(bram_dout),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .bad_type_cnt(bad_type_cnt), .seq_err_cnt(seq_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_en) bram_dout <= frame_mem[bram_addr[8:2]];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Monitor: pops one expected beat per accepted handshake.
  initial begin
    logic [63:0] exp_beat;
    int inflight;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (bram_en) en_count++;
        if (track_on) begin
          inflight = (en_count - en_base - 1) - (accepted - acc_base);
          if (inflight > max_inflight) max_inflight = inflight;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none",
                     {m_axis_tlast, m_axis_tuser, m_axis_tdata});
          end else begin
            exp_beat = exp_q.pop_front();
            chk($sformatf("beat%0d", accepted),
                {30'd0, m_axis_tlast, m_axis_tuser, m_axis_tdata}, exp_beat);
          end
          accepted++;
        end
      end
    end
  end

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #2;
      if (bp_on) begin
        m_axis_tready = (ph == 0);
        ph = (ph == 2) ? 0 : ph + 1;
      end else begin
        m_axis_tready = 1'b1;
      end
    end
  end

  task automatic load_frame(input logic [31:0] w0, input logic [31:0] seq);
    for (int i = 0; i < 128; i++) begin
      if (i == 0)                frame_mem[i] = w0;
      else if (i == 1)           frame_mem[i] = seq;
      else if (i >= 4 && i < 16) frame_mem[i] = 32'hbad0_0000 | i;
      else                       frame_mem[i] = i;
    end
  endtask

  // Expected stream: type, seq, 2, 3, then words 16..123 whose value equals their index.
  task automatic expect_frame(input logic [31:0] seq);
    logic [31:0] d;
    for (int b = 0; b < 112; b++) begin
      if (b == 0)      d = FRAME_TYPE;
      else if (b == 1) d = seq;
      else if (b < 4)  d = b;
      else             d = b + 12;
      exp_q.push_back({30'd0, (b == 111), (b == 0), d});
    end
  endtask

  task automatic fire();
    @(posedge clk);
    #2 frame_irq = 1'b1;
    @(posedge clk);
    #2 frame_irq = 1'b0;
  endtask

  task automatic wait_done(input logic [31:0] target);
    int n = 0;
    while (frame_cnt != target && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("frame_cnt", frame_cnt, target);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bram_rst", bram_rst, 1'b1);
    chk("rst_bram_en", bram_en, 1'b0);
    chk("rst_bram_addr", bram_addr, 13'd0);
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata_tags", {m_axis_tlast, m_axis_tuser, m_axis_tdata}, 34'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_counters", {frame_cnt, drop_cnt, bad_type_cnt, seq_err_cnt}, 80'd0);
    @(posedge clk);
    #2 resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("bram_clk", bram_clk, 1'b1);
    chk("bram_rst_released", bram_rst, 1'b0);

    // Valid frame with latency measurement from the trigger edge.
    load_frame(FRAME_TYPE, 32'd5);
    expect_frame(32'd5);
    @(posedge clk);
    #2 frame_irq = 1'b1;
    @(posedge clk);
    #2 frame_irq = 1'b0;
    lat = 0;
    while (!m_axis_tvalid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("first_tvalid_latency", lat, 5);
    wait_done(32'd1);

    // Bad frame type: rejected after the compare, nothing streamed.
    load_frame(32'hdeadbeef, 32'd99);
    @(posedge clk);
    #2 frame_irq = 1'b1;
    @(posedge clk);
    #2 frame_irq = 1'b0;
    @(posedge clk);
    #1;
    chk("badtype_busy_high", busy, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("badtype_busy_low", busy, 1'b0);
    chk("bad_type_cnt", bad_type_cnt, 16'd1);
    repeat (10) @(posedge clk);
    chk("badtype_no_frame", frame_cnt, 32'd1);

    // Backpressure: tready 1 on / 2 off.
    load_frame(FRAME_TYPE, 32'd6);
    expect_frame(32'd6);
    en_base = en_count;
    acc_base = accepted;
    track_on = 1'b1;
    bp_on = 1'b1;
    fire();
    wait_done(32'd2);
    track_on = 1'b0;
    bp_on = 1'b0;
    chk("bp_reads_issued", en_count - en_base, 113);
    chk("bp_beats", accepted - acc_base, 112);
    chk("bp_inflight_le_5", (max_inflight <= FIFO_DEPTH + 1), 1'b1);

    // Sequence 7, 8, 10: only the jump to 10 is a discontinuity.
    load_frame(FRAME_TYPE, 32'd7);
    expect_frame(32'd7);
    fire();
    wait_done(32'd3);
    chk("seq_after_7", seq_err_cnt, 16'd0);
    load_frame(FRAME_TYPE, 32'd8);
    expect_frame(32'd8);
    fire();
    wait_done(32'd4);
    chk("seq_after_8", seq_err_cnt, 16'd0);
    load_frame(FRAME_TYPE, 32'd10);
    expect_frame(32'd10);
    fire();
    wait_done(32'd5);
    chk("seq_after_10", seq_err_cnt, SEQ_ERR_EXP);

    // Overrun: second irq edge at beat 50 is dropped, frame completes.
    load_frame(FRAME_TYPE, 32'd11);
    expect_frame(32'd11);
    acc_base = accepted;
    fire();
    n = 0;
    while (accepted - acc_base < 50 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reached_beat50", (accepted - acc_base >= 50), 1'b1);
    fire();
    wait_done(32'd6);
    chk("drop_cnt", drop_cnt, 16'd1);
    chk("seq_after_11", seq_err_cnt, SEQ_ERR_EXP);

    // Reset at beat 30 of the next frame.
    load_frame(FRAME_TYPE, 32'd12);
    expect_frame(32'd12);
    acc_base = accepted;
    fire();
    n = 0;
    while (accepted - acc_base < 30 && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("reached_beat30", (accepted - acc_base >= 30), 1'b1);
    resetn = 1'b0;
    #1;
    chk("midrst_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_counters", {frame_cnt, drop_cnt, bad_type_cnt, seq_err_cnt}, 80'd0);
    chk("midrst_bram_en", bram_en, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("postrst_tvalid", m_axis_tvalid, 1'b0);

    // Clean frame after reset; the first frame is never a sequence error.
    load_frame(FRAME_TYPE, 32'd100);
    expect_frame(32'd100);
    fire();
    wait_done(32'd1);
    chk("postrst_seq", seq_err_cnt, 16'd0);
    chk("postrst_drop", drop_cnt, 16'd0);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
